tpu_job_sequencer: RTL and testbench

Drives a DEPTH x DEPTH weight-stationary systolic TPU through one complete job: weight load, diagonally skewed data streaming, pipeline drain, result capture. It owns the TPU's `control`, `wt_arr` and `data_arr` inputs and samples its accumulator outputs. Benches no longer have to hand-write the skew pattern or pad with X.

---
 rtl/tpu_seq_pkg.sv | 17 +
 rtl/tpu_skew_buffer.sv | 31 +++
 rtl/tpu_job_sequencer.sv | 152 +++++++++++++++
 tb/tb_tpu_job_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_seq_pkg.sv
// Shared state encoding, vector-count width and lane/column slicing helpers
// for the TPU job sequencer and its skew buffer.
package tpu_seq_pkg;

  typedef enum logic [2:0] {IDLE, LOAD_WT, SETTLE, STREAM, DRAIN, DONE} seq_state_t;

  localparam int VEC_CNT_W = 16;

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

  function automatic int col_lo(input int col, input int width, input int depth);
    return col * depth * width;
  endfunction

endpackage

// File: rtl/tpu_skew_buffer.sv
// Diagonal skew for the systolic array: lane i is delayed i+1 cycles through
// its own shift register, and non-data slots are filled with zero.
module tpu_skew_buffer
  import tpu_seq_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DEPTH*BIT_WIDTH-1:0] vec,
  input  logic                       vec_valid,
  output logic [DEPTH*BIT_WIDTH-1:0] skew_out
);

  for (genvar i = 0; i < DEPTH; i++) begin : g_lane
    logic [BIT_WIDTH-1:0] sr [0:i];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j <= i; j++) sr[j] <= '0;
      end else begin
        sr[0] <= vec_valid ? vec[lane_lo(i, BIT_WIDTH) +: BIT_WIDTH] : '0;
        for (int j = 1; j <= i; j++) sr[j] <= sr[j-1];
      end
    end

    assign skew_out[lane_lo(i, BIT_WIDTH) +: BIT_WIDTH] = sr[i];
  end

endmodule

// File: rtl/tpu_job_sequencer.sv
// Runs one weight-stationary TPU job: weight load, skewed streaming, drain and
// result capture. Define TPU_SEQ_PERF_EN to add job/stall cycle counters.
module tpu_job_sequencer
  import tpu_seq_pkg::*;
#(
  parameter int BIT_WIDTH    = 16,
  parameter int ACC_WIDTH    = 40,
  parameter int DEPTH        = 4,
  parameter int DRAIN_CYCLES = 2*DEPTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [DEPTH*DEPTH*BIT_WIDTH-1:0] wt_mat,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DEPTH*BIT_WIDTH-1:0]       in_data,
  input  logic                             in_last,
  output logic                             control,
  output logic [DEPTH*BIT_WIDTH-1:0]       wt_arr,
  output logic [DEPTH*BIT_WIDTH-1:0]       data_arr,
  input  logic [DEPTH*ACC_WIDTH-1:0]       acc_in,
  output logic [DEPTH*ACC_WIDTH-1:0]       res_out,
  output logic                             res_valid,
  output logic                             busy,
  output logic [VEC_CNT_W-1:0]             vec_count
`ifdef TPU_SEQ_PERF_EN
  ,
  output logic [31:0]                      job_cycles,
  output logic [31:0]                      stall_cycles
`endif
);

  localparam int VW = DEPTH * BIT_WIDTH;
  localparam int KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  seq_state_t                     state;
  logic [KW-1:0]                  k;
  logic [DW-1:0]                  dcnt;
  logic [DEPTH*DEPTH*BIT_WIDTH-1:0] wt_reg;
  logic                           xfer;

  function automatic logic [VEC_CNT_W-1:0] sat_inc_cnt(input logic [VEC_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // in_ready is registered and only ever high in STREAM
  assign xfer = in_valid & in_ready;

  tpu_skew_buffer #(
    .BIT_WIDTH(BIT_WIDTH),
    .DEPTH    (DEPTH)
  ) u_skew (
    .clk      (clk),
    .rst      (rst),
    .vec      (in_data),
    .vec_valid(xfer),
    .skew_out (data_arr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      dcnt      <= '0;
      wt_reg    <= '0;
      control   <= 1'b0;
      wt_arr    <= '0;
      in_ready  <= 1'b0;
      res_out   <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      vec_count <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            wt_reg    <= wt_mat;
            vec_count <= '0;
            k         <= '0;
            control   <= 1'b1;
            wt_arr    <= wt_mat[col_lo(0, BIT_WIDTH, DEPTH) +: VW];
            busy      <= 1'b1;
            state     <= LOAD_WT;
          end
        end
        LOAD_WT: begin
          if (k == KW'(DEPTH-1)) begin
            control <= 1'b0;
            wt_arr  <= '0;
            state   <= SETTLE;
          end else begin
            k      <= k + 1'b1;
            wt_arr <= wt_reg[col_lo(int'(k) + 1, BIT_WIDTH, DEPTH) +: VW];
          end
        end
        SETTLE: begin
          in_ready <= 1'b1;
          state    <= STREAM;
        end
        STREAM: begin
          if (xfer) begin
            vec_count <= sat_inc_cnt(vec_count);
            if (in_last) begin
              in_ready <= 1'b0;
              dcnt     <= '0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Capture on the edge entering DONE so res_valid and res_out align
          if (dcnt == DW'(DRAIN_CYCLES-1)) begin
            res_out   <= acc_in;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TPU_SEQ_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // The accepting IDLE cycle counts as the first job cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_cycles   <= '0;
      stall_cycles <= '0;
    end else if (state == IDLE && start) begin
      job_cycles   <= 32'd1;
      stall_cycles <= '0;
    end else if (busy) begin
      job_cycles <= sat_inc32(job_cycles);
      if (state == STREAM && !xfer) stall_cycles <= sat_inc32(stall_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// Randomized bench for tpu_job_sequencer against a cycle-timeline reference
// model of job phases, skewed data and result capture.
module tb_tpu_job_sequencer;

  localparam int BW = 16;
  localparam int AW = 40;
  localparam int D  = 4;
  localparam int DR = 2*D;
  localparam int VW = D*BW;
  localparam int CW = D*AW;

  typedef logic [CW-1:0] cv_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [D*VW-1:0] wt_mat = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          control;
  logic [VW-1:0] wt_arr;
  logic [VW-1:0] data_arr;
  logic [CW-1:0] acc_in = '0;
  logic [CW-1:0] res_out;
  logic          res_valid;
  logic          busy;
  logic [15:0]   vec_count;
`ifdef TPU_SEQ_PERF_EN
  logic [31:0]   job_cycles;
  logic [31:0]   stall_cycles;
`endif

  tpu_job_sequencer #(
    .BIT_WIDTH(BW), .ACC_WIDTH(AW), .DEPTH(D), .DRAIN_CYCLES(DR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .wt_mat(wt_mat),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .control(control), .wt_arr(wt_arr), .data_arr(data_arr), .acc_in(acc_in),
    .res_out(res_out), .res_valid(res_valid), .busy(busy), .vec_count(vec_count)
`ifdef TPU_SEQ_PERF_EN
    , .job_cycles(job_cycles), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check_val(input string tag, input cv_t got, input cv_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [D*VW-1:0] rand_wt();
    return {rand_vec(), rand_vec(), rand_vec(), rand_vec()};
  endfunction

  // Reference model: a job is a timeline of edge numbers relative to the
  // accepting edge s and the last-transfer edge L.
  int  edge_n = 0;
  int  s_edge = 0;
  int  l_edge = -1;
  bit  m_active = 1'b0;
  bit  m_xfer = 1'b0;
  int  vcnt = 0;
  int  jobs_done = 0;
  int  res_pulses = 0;
  logic [D*VW-1:0] m_wt = '0;
  cv_t m_res = '0;
  logic [VW-1:0] pushed [int];

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_active = 1'b0;
      m_xfer   = 1'b0;
      l_edge   = -1;
      vcnt     = 0;
      m_res    = '0;
      pushed.delete();
    end else begin
      edge_n++;
      m_xfer = 1'b0;
      if (!m_active) begin
        if (start) begin
          m_active = 1'b1;
          s_edge   = edge_n;
          l_edge   = -1;
          vcnt     = 0;
          m_wt     = wt_mat;
        end
      end else begin
        if (l_edge < 0 && (edge_n - 1 - s_edge) >= D + 1 && in_valid) begin
          m_xfer = 1'b1;
          pushed[edge_n] = in_data;
          if (vcnt < 65535) vcnt++;
          if (in_last) l_edge = edge_n;
        end
        if (l_edge >= 0 && edge_n == l_edge + DR) m_res = acc_in;
        if (l_edge >= 0 && edge_n == l_edge + DR + 1) begin
          m_active = 1'b0;
          jobs_done++;
        end
      end
    end
  end

  // Compare every output on the falling edge, then present a fresh acc_in
  initial forever begin
    logic [VW-1:0] exp_data;
    int r;
    @(negedge clk);
    r = edge_n - s_edge;
    exp_data = '0;
    for (int i = 0; i < D; i++)
      if (pushed.exists(edge_n - i)) exp_data[i*BW +: BW] = pushed[edge_n - i][i*BW +: BW];
    check_val("busy",      cv_t'(busy),      cv_t'(m_active));
    check_val("control",   cv_t'(control),   cv_t'(m_active && r < D));
    check_val("wt_arr",    cv_t'(wt_arr),    (m_active && r < D) ? cv_t'(m_wt[r*VW +: VW]) : cv_t'(0));
    check_val("in_ready",  cv_t'(in_ready),  cv_t'(m_active && l_edge < 0 && r >= D + 1));
    check_val("data_arr",  cv_t'(data_arr),  cv_t'(exp_data));
    check_val("res_valid", cv_t'(res_valid), cv_t'(m_active && l_edge >= 0 && edge_n == l_edge + DR));
    check_val("res_out",   res_out,          m_res);
    check_val("vec_count", cv_t'(vec_count), cv_t'(vcnt));
    if (res_valid) res_pulses++;
    acc_in = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  end

  task automatic run_job(input logic [D*VW-1:0] w, input logic [VW-1:0] v0, input int nvec,
                         input int gap, input bit rnd, input bit poke);
    int sent = 0;
    int hold = 0;
    int budget = 0;
    @(negedge clk);
    start = 1'b1;
    wt_mat = w;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (sent < nvec && budget < 400) begin
      in_valid = (hold == 0) && (!rnd || ($urandom_range(0, 2) != 0));
      in_data  = (sent == 0) ? v0 : rand_vec();
      in_last  = (sent == nvec - 1);
      start    = poke && (sent == 1);
      @(negedge clk);
      budget++;
      if (m_xfer) begin
        sent++;
        hold = gap;
      end else if (hold > 0) begin
        hold--;
      end
    end
    check_val("vectors_sent", cv_t'(sent), cv_t'(nvec));
    in_valid = 1'b0;
    in_last = 1'b0;
    start = 1'b0;
    in_data = '0;
    budget = 0;
    while (m_active && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check_val("idle_after_job", cv_t'(busy), cv_t'(0));
    check_val("res_pulses", cv_t'(res_pulses), cv_t'(jobs_done));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    logic [D*VW-1:0] w1;
    int budget;
    w1 = {64'h0000_0000_0000_000a, 64'h0000_0000_000a_0000,
          64'h0000_000a_0000_0000, 64'h000a_0000_0000_0000};
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // valid with no job running must be ignored
    in_valid = 1'b1;
    repeat (4) begin
      in_data = rand_vec();
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_val("idle_vec_count", cv_t'(vec_count), cv_t'(0));

    run_job(w1, 64'h000c_0009_0006_0003, 1, 0, 1'b0, 1'b0);

    run_job(rand_wt(), rand_vec(), 3, 2, 1'b0, 1'b0);
    check_val("bubble_vec_count", cv_t'(vec_count), cv_t'(3));
`ifdef TPU_SEQ_PERF_EN
    check_val("stall_cycles", cv_t'(stall_cycles), cv_t'(4));
    check_val("job_cycles", cv_t'(job_cycles), cv_t'(l_edge + DR + 2 - s_edge));
`endif

    run_job(rand_wt(), rand_vec(), 4, 0, 1'b0, 1'b1);

    for (int j = 0; j < 6; j++)
      run_job(rand_wt(), rand_vec(), $urandom_range(1, 6), 0, 1'b1, 1'b0);

    // asynchronous reset while draining
    @(negedge clk);
    start = 1'b1;
    wt_mat = rand_wt();
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_last = 1'b1;
    in_data = 64'h4444_3333_2222_1111;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!m_xfer && budget < 50);
    in_valid = 1'b0;
    in_last = 1'b0;
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check_val("rst_busy",      cv_t'(busy),      cv_t'(0));
    check_val("rst_control",   cv_t'(control),   cv_t'(0));
    check_val("rst_data_arr",  cv_t'(data_arr),  cv_t'(0));
    check_val("rst_res_valid", cv_t'(res_valid), cv_t'(0));
    check_val("rst_in_ready",  cv_t'(in_ready),  cv_t'(0));
    @(negedge clk);
    rst = 1'b0;

    run_job(w1, rand_vec(), 2, 1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
